// File: rtl/mult8x8_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
// Partial-product order is a_lo*b_lo, a_lo*b_hi, a_hi*b_lo, a_hi*b_hi.
package mult8x8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CODE_IDLE = 3'b111;
  localparam logic [2:0] CODE_DONE = 3'b100;

  localparam logic [3:0] SHIFT_CNT0 = 4'd0;
  localparam logic [3:0] SHIFT_CNT1 = 4'd4;
  localparam logic [3:0] SHIFT_CNT2 = 4'd4;
  localparam logic [3:0] SHIFT_CNT3 = 4'd8;

  function automatic logic [3:0] shift_of(input logic [1:0] cnt);
    case (cnt)
      2'd0:    return SHIFT_CNT0;
      2'd1:    return SHIFT_CNT1;
      2'd2:    return SHIFT_CNT2;
      default: return SHIFT_CNT3;
    endcase
  endfunction

endpackage

// File: rtl/mult8x8_seq_ctrl_if.sv
// Operand/result bundle between the multiplier and its host.
interface mult8x8_seq_ctrl_if;

  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product8x8_out;
  logic        done_flag;
  logic [2:0]  state_code;

  modport master (
    output start, dataa, datab,
    input  product8x8_out, done_flag, state_code
  );

  modport slave (
    input  start, dataa, datab,
    output product8x8_out, done_flag, state_code
  );

endinterface

// File: rtl/mult4x4.sv
// Combinational 4x4 -> 8 unsigned nibble multiplier.
module mult4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'h0, a} * {4'h0, b};

endmodule

// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 multiplier, four cycles
// of shifted accumulation, registered outputs only.
//
// state | meaning
// IDLE  | waiting for start after reset
// CALC  | one nibble product accumulated per cycle, cnt selects nibbles
// DONE  | result held with done_flag until the next start
module mult8x8_seq_ctrl
  import mult8x8_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  mult8x8_seq_ctrl_if.slave  bus
);

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [7:0]  a_r, a_nxt;
  logic [7:0]  b_r, b_nxt;
  logic [15:0] acc, acc_nxt;
  logic        done_r, done_nxt;
  logic [2:0]  code_r, code_nxt;

  logic [3:0]  a_nib, b_nib;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;

  assign a_nib = cnt[1] ? a_r[7:4] : a_r[3:0];
  assign b_nib = cnt[0] ? b_r[7:4] : b_r[3:0];

  mult4x4 u_mult4x4 (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  assign pp_shifted = {8'h00, pp} << shift_of(cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      a_r    <= 8'h00;
      b_r    <= 8'h00;
      acc    <= 16'h0000;
      done_r <= 1'b0;
      code_r <= CODE_IDLE;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      a_r    <= a_nxt;
      b_r    <= b_nxt;
      acc    <= acc_nxt;
      done_r <= done_nxt;
      code_r <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = a_r;
    b_nxt     = b_r;
    acc_nxt   = acc;
    done_nxt  = done_r;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          a_nxt     = bus.dataa;
          b_nxt     = bus.datab;
          acc_nxt   = 16'h0000;
          cnt_nxt   = 2'd0;
          done_nxt  = 1'b0;
          state_nxt = CALC;
        end
      end
      CALC: begin
        acc_nxt = acc + pp_shifted;
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  // The display code is derived from next-state so it lands on the same edge.
  always_comb begin
    code_nxt = CODE_IDLE;
    case (state_nxt)
      CALC:    code_nxt = {1'b0, cnt_nxt};
      DONE:    code_nxt = CODE_DONE;
      default: code_nxt = CODE_IDLE;
    endcase
  end

  assign bus.product8x8_out = acc;
  assign bus.done_flag      = done_r;
  assign bus.state_code     = code_r;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Self-checking bench for mult8x8_seq_ctrl: directed cases plus random operands
// compared against an arithmetic reference of the partial-sum sequence.
module tb_mult8x8_seq_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mult8x8_seq_ctrl_if bus ();

  mult8x8_seq_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Running sum after k partial products, in the fixed issue order.
  function automatic logic [15:0] model_sum(input logic [7:0] a, input logic [7:0] b, input int k);
    int t [4];
    int s;
    int al, ah, bl, bh;
    al = a % 16; ah = a / 16; bl = b % 16; bh = b / 16;
    t[0] = al * bl;
    t[1] = al * bh * 16;
    t[2] = ah * bl * 16;
    t[3] = ah * bh * 256;
    s = 0;
    for (int i = 0; i < k; i++) s += t[i];
    return s[15:0];
  endfunction

  function automatic logic [15:0] full_product(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input string tag);
    bus.dataa = a;
    bus.datab = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, "_acc_e0"}, bus.product8x8_out, 16'h0000);
    chk({tag, "_done_e0"}, {15'd0, bus.done_flag}, 16'd0);
    chk({tag, "_code_e0"}, {13'd0, bus.state_code}, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("%s_sum%0d", tag, k), bus.product8x8_out, model_sum(a, b, k));
      if (k < 4) begin
        chk($sformatf("%s_code%0d", tag, k), {13'd0, bus.state_code}, 16'(k));
        chk($sformatf("%s_done%0d", tag, k), {15'd0, bus.done_flag}, 16'd0);
      end else begin
        chk({tag, "_final"}, bus.product8x8_out, full_product(a, b));
        chk({tag, "_done"}, {15'd0, bus.done_flag}, 16'd1);
        chk({tag, "_code_done"}, {13'd0, bus.state_code}, 16'h0004);
      end
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    bus.start = 1'b0;
    bus.dataa = 8'h00;
    bus.datab = 8'h00;
    #12;
    chk("rst_acc", bus.product8x8_out, 16'h0000);
    chk("rst_done", {15'd0, bus.done_flag}, 16'd0);
    chk("rst_code", {13'd0, bus.state_code}, 16'h0007);
    reset_n = 1'b1;
    step();
    chk("idle_code", {13'd0, bus.state_code}, 16'h0007);

    run_mult(8'hFF, 8'hFF, "ffxff");
    chk("ffxff_const", bus.product8x8_out, 16'hFE01);
    run_mult(8'h12, 8'h34, "12x34");
    chk("12x34_const", bus.product8x8_out, 16'h03A8);
    run_mult(8'h00, 8'hA7, "00xa7");
    run_mult(8'h0F, 8'hF0, "0fxf0");
    chk("0fxf0_const", bus.product8x8_out, 16'h0E10);

    // start pulsed mid-calculation with new operands must be ignored
    bus.dataa = 8'h5A;
    bus.datab = 8'h3C;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    bus.dataa = 8'h02;
    bus.datab = 8'h03;
    step();
    bus.start = 1'b0;
    chk("ign_sum2", bus.product8x8_out, model_sum(8'h5A, 8'h3C, 2));
    chk("ign_code2", {13'd0, bus.state_code}, 16'h0002);
    step();
    step();
    chk("ign_final", bus.product8x8_out, 16'h1518);
    chk("ign_done", {15'd0, bus.done_flag}, 16'd1);
    run_mult(8'h02, 8'h03, "02x03");
    chk("02x03_const", bus.product8x8_out, 16'h0006);

    // start held high: a result every 5 cycles
    bus.dataa = 8'h10;
    bus.datab = 8'h10;
    bus.start = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      chk($sformatf("hold_done_e%0d", k), {15'd0, bus.done_flag}, (k % 5 == 4) ? 16'd1 : 16'd0);
      if (k % 5 == 4) chk($sformatf("hold_prod_e%0d", k), bus.product8x8_out, 16'h0100);
    end
    bus.start = 1'b0;

    // asynchronous reset in the middle of a calculation
    bus.dataa = 8'hC3;
    bus.datab = 8'h7E;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("pre_rst_code", {13'd0, bus.state_code}, 16'h0002);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_acc", bus.product8x8_out, 16'h0000);
    chk("midrst_done", {15'd0, bus.done_flag}, 16'd0);
    chk("midrst_code", {13'd0, bus.state_code}, 16'h0007);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst_code%0d", k), {13'd0, bus.state_code}, 16'h0007);
      chk($sformatf("post_rst_done%0d", k), {15'd0, bus.done_flag}, 16'd0);
      chk($sformatf("post_rst_acc%0d", k), bus.product8x8_out, 16'h0000);
    end

    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_mult(ra, rb, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
